node_initiator: RTL and testbench

NODE_INITIATOR -- requirements
Module: node_initiator

---
 rtl/node_initiator_pkg.sv | 21 ++
 rtl/node_req_fifo.sv | 53 +++++
 rtl/node_initiator.sv | 137 +++++++++++++
 tb/tb_node_initiator.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/node_initiator_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | node_initiator_pkg : shared constants and FSM encoding for node_initiator |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package node_initiator_pkg;

  localparam int c_WIDTH      = 16;
  localparam int c_TIMEOUT    = 255;
  localparam int c_FIFO_DEPTH = 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/node_req_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | node_req_fifo : 2-entry request buffer, push while full is dropped       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module node_req_fifo
  import node_initiator_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] r_mem [c_FIFO_DEPTH];
  logic          r_wr;
  logic          r_rd;
  logic [1:0]    r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign full   = (r_count == 2'(c_FIFO_DEPTH));
  assign empty  = (r_count == 2'd0);
  assign dout   = r_mem[r_rd];

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr] <= din;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wr <= ~r_wr;
      if (w_pop)  r_rd <= ~r_rd;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule
`default_nettype wire

// File: rtl/node_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | node_initiator : queues operand pairs, launches child node, returns rsp  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module node_initiator
  import node_initiator_pkg::*;
#(
  parameter int WIDTH   = c_WIDTH,
  parameter int TIMEOUT = c_TIMEOUT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [WIDTH-1:0] REQ_A,
  input  logic [WIDTH-1:0] REQ_B,
  output logic             N_ST,
  output logic [WIDTH-1:0] N_IN0,
  output logic [WIDTH-1:0] N_IN1,
  input  logic             N_RD,
  input  logic [WIDTH-1:0] N_RES,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [WIDTH-1:0] RSP_DATA,
  output logic             RSP_ERR
);

  localparam int                c_CW       = $clog2(TIMEOUT + 1);
  localparam logic [c_CW-1:0]   c_CNT_LAST = c_CW'(TIMEOUT - 1);

  state_t             r_state;
  logic [c_CW-1:0]    r_cnt;
  logic               r_st;
  logic [WIDTH-1:0]   r_in0;
  logic [WIDTH-1:0]   r_in1;
  logic               r_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_data;
  logic               r_rsp_err;

  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [2*WIDTH-1:0] w_head;

  assign REQ_READY = ~w_full;
  assign w_push    = REQ_VALID & ~w_full;
  // Only pop when the child is idle, so a busy child is never restarted.
  assign w_pop     = (r_state == S_IDLE) & ~w_empty & N_RD;

  node_req_fifo #(
    .DW (2 * WIDTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (w_push),
    .din   ({REQ_A, REQ_B}),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_st        <= 1'b0;
      r_in0       <= '0;
      r_in1       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_st <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_in0   <= w_head[2*WIDTH-1:WIDTH];
            r_in1   <= w_head[WIDTH-1:0];
            r_st    <= 1'b1;
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_cnt   <= '0;
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (!N_RD) begin
            r_cnt   <= '0;
            r_state <= S_WAIT_DONE;
          end else if (r_cnt == c_CNT_LAST) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (N_RD) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= N_RES;
            r_rsp_err   <= 1'b0;
            r_state     <= S_RESP;
          end else if (r_cnt == c_CNT_LAST) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        S_RESP: begin
          if (RSP_READY) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign N_ST      = r_st;
  assign N_IN0     = r_in0;
  assign N_IN1     = r_in1;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_DATA  = r_rsp_data;
  assign RSP_ERR   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_node_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_node_initiator : directed + random bench with projection child model  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_node_initiator;

  localparam int W  = 16;
  localparam int TO = 255;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         REQ_VALID = 1'b0;
  logic         REQ_READY;
  logic [W-1:0] REQ_A = '0;
  logic [W-1:0] REQ_B = '0;
  logic         N_ST;
  logic [W-1:0] N_IN0;
  logic [W-1:0] N_IN1;
  logic         N_RD;
  logic [W-1:0] N_RES;
  logic         RSP_VALID;
  logic         RSP_READY = 1'b0;
  logic [W-1:0] RSP_DATA;
  logic         RSP_ERR;

  always #5 CLK = ~CLK;

  node_initiator #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_A     (REQ_A),
    .REQ_B     (REQ_B),
    .N_ST      (N_ST),
    .N_IN0     (N_IN0),
    .N_IN1     (N_IN1),
    .N_RD      (N_RD),
    .N_RES     (N_RES),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_DATA  (RSP_DATA),
    .RSP_ERR   (RSP_ERR)
  );

  // Projection child: returns IN0, busy (N_RD low) for busy_len cycles after a strobe.
  logic         child_rd  = 1'b1;
  logic [W-1:0] child_res = '0;
  int           child_cnt = 0;
  int           busy_len  = 2;
  bit           never_ack = 1'b0;
  bit           force_busy = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      child_rd  <= 1'b1;
      child_cnt <= 0;
    end else if (N_ST && !never_ack) begin
      child_rd  <= 1'b0;
      child_cnt <= busy_len;
      child_res <= N_IN0;
    end else if (child_cnt > 1) begin
      child_cnt <= child_cnt - 1;
    end else if (child_cnt == 1) begin
      child_cnt <= 0;
      child_rd  <= 1'b1;
    end
  end

  assign N_RD  = child_rd & ~force_busy;
  assign N_RES = child_res;

  typedef struct packed {
    logic [W-1:0] d;
    logic         e;
  } rsp_t;

  rsp_t got_q[$];
  rsp_t exp_q[$];
  int   cyc = 0;
  int   st_pulses = 0;
  int   st_bad = 0;
  logic prev_st = 1'b0;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (!RST && RSP_VALID && RSP_READY) got_q.push_back({RSP_DATA, RSP_ERR});
    if (N_ST) begin
      st_pulses++;
      if (prev_st || !N_RD) st_bad++;
    end
    prev_st = N_ST;
  end

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one request, wait (bounded) for acceptance, record expected response.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
    int guard;
    rsp_t e;
    guard = 0;
    REQ_A = a;
    REQ_B = b;
    REQ_VALID = 1'b1;
    while (!REQ_READY && guard < 600) begin
      @(negedge CLK);
      guard++;
    end
    if (!REQ_READY) check("accept", {31'd0, REQ_READY}, 32'd1);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    acc = cyc;
    e.d = never_ack ? '0 : a;
    e.e = never_ack;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag, input bit rnd_ready);
    int guard;
    rsp_t g, e;
    guard = 0;
    while (got_q.size() < exp_q.size() && guard < 3000) begin
      @(negedge CLK);
      if (rnd_ready) RSP_READY = 1'($urandom_range(0, 1));
      guard++;
    end
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_data"}, {16'd0, g.d}, {16'd0, e.d});
      check({tag, "_err"}, {31'd0, g.e}, {31'd0, e.e});
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic wait_valid(output int at);
    int guard;
    guard = 0;
    while (!RSP_VALID && guard < 400) begin
      @(negedge CLK);
      guard++;
    end
    at = cyc;
  endtask

  initial begin
    int acc, at, s, st0, cnt;
    logic [W-1:0] cap;
    bit stable;

    // Reset values, checked while reset is still held.
    RST = 1'b1;
    @(negedge CLK);
    check("rst_req_ready", {31'd0, REQ_READY}, 32'd1);
    check("rst_n_st", {31'd0, N_ST}, 32'd0);
    check("rst_n_in", {N_IN0, N_IN1}, 32'd0);
    check("rst_rsp", {14'd0, RSP_VALID, RSP_ERR, RSP_DATA}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Single request through the projection child.
    RSP_READY = 1'b1;
    st0 = st_pulses;
    send(16'h1234, 16'h00ff, acc);
    wait_valid(at);
    check("single_latency_le6", {31'd0, (at - acc) <= 6}, 32'd1);
    check("single_n_in0", {16'd0, N_IN0}, 32'h1234);
    check("single_n_in1", {16'd0, N_IN1}, 32'h00ff);
    drain("single", 1'b0);
    check("single_one_strobe", st_pulses - st0, 32'd1);

    // Three back-to-back requests.
    st0 = st_pulses;
    send(16'h0001, 16'h0, acc);
    send(16'h0002, 16'h0, acc);
    send(16'h0003, 16'h0, acc);
    check("b2b_ready_low_when_full", {31'd0, REQ_READY}, 32'd0);
    drain("b2b", 1'b0);
    check("b2b_strobes", st_pulses - st0, 32'd3);
    check("b2b_strobe_spacing", st_bad, 32'd0);

    // Child never acknowledges: error after TIMEOUT cycles in WAIT_ACK.
    never_ack = 1'b1;
    send(16'hbeef, 16'h1, acc);
    cnt = 0;
    while (!N_ST && cnt < 20) begin
      @(negedge CLK);
      cnt++;
    end
    s = cyc;
    @(negedge CLK);
    wait_valid(at);
    check("timeout_cycles", at - (s + 1), TO);
    check("timeout_err", {31'd0, RSP_ERR}, 32'd1);
    check("timeout_data", {16'd0, RSP_DATA}, 32'd0);
    drain("timeout", 1'b0);
    never_ack = 1'b0;

    // Child busy before the request: no strobe until it frees up.
    force_busy = 1'b1;
    st0 = st_pulses;
    send(16'h5a5a, 16'h2, acc);
    repeat (8) @(negedge CLK);
    check("busy_no_strobe", st_pulses - st0, 32'd0);
    check("busy_no_rsp", {31'd0, RSP_VALID}, 32'd0);
    force_busy = 1'b0;
    drain("busy", 1'b0);
    check("busy_one_strobe", st_pulses - st0, 32'd1);

    // Consumer stalls: response held, queued request not launched.
    RSP_READY = 1'b0;
    send(16'h0a0b, 16'h3, acc);
    wait_valid(at);
    cap = RSP_DATA;
    send(16'h0c0d, 16'h4, acc);
    st0 = st_pulses;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (!(RSP_VALID === 1'b1 && RSP_DATA === cap && RSP_ERR === 1'b0)) stable = 1'b0;
    end
    check("stall_stable", {31'd0, stable}, 32'd1);
    check("stall_data", {16'd0, cap}, 32'h0a0b);
    check("stall_no_strobe", st_pulses - st0, 32'd0);
    RSP_READY = 1'b1;
    drain("stall", 1'b0);

    // Reset in WAIT_DONE with a second request queued.
    busy_len = 6;
    send(16'h1111, 16'h5, acc);
    send(16'h2222, 16'h6, acc);
    cnt = 0;
    while (!N_ST && cnt < 20) begin
      @(negedge CLK);
      cnt++;
    end
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("mid_rst_n_st", {31'd0, N_ST}, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
    check("mid_rst_req_ready", {31'd0, REQ_READY}, 32'd1);
    RST = 1'b0;
    exp_q.delete();
    st0 = st_pulses;
    repeat (30) @(negedge CLK);
    check("mid_rst_no_rsp", got_q.size(), 32'd0);
    check("mid_rst_no_strobe", st_pulses - st0, 32'd0);
    got_q.delete();

    // Randomized operands, child latency and consumer back-pressure.
    for (int it = 0; it < 25; it++) begin
      busy_len = $urandom_range(1, 5);
      RSP_READY = 1'b1;
      cnt = $urandom_range(1, 3);
      for (int k = 0; k < cnt; k++) send(W'($urandom), W'($urandom), acc);
      drain("rand", 1'b1);
    end
    check("rand_strobe_spacing", st_bad, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
